axi_frame_read_ctrl: RTL and testbench
======================================

Name: axi_frame_read_ctrl

Overview:
- Sequences AXI4 read bursts from the image RAM (axi_ram) so that one frame of IMG_WIDTH x IMG_HEIGHT 32-bit pixels streams out in raster order on an AXI-Stream master port.
- Sits between the top-level start control and the rectification pipeline.
- Provides tuser on the first pixel of a frame (start of frame) and tlast on the last pixel of each line.
- Keeps one burst outstanding at a time and honours downstream backpressure.

Parameters:
- DATA_WIDTH, 32, AXI and stream data width.
- ADDR_WIDTH, 16, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, bytes per beat.
- ID_WIDTH, 8, AXI ID width.
- IMG_WIDTH, 64, pixels (beats) per line. Must be a multiple of BURST_LEN.
- IMG_HEIGHT, 48, lines per frame.
- BURST_LEN, 16, beats per burst, 1..256. BURST_LEN*STRB_WIDTH must be ≤ 4096.
- BASE_ADDR, 0, frame byte address. Must be aligned to BURST_LEN*STRB_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  level; begins a frame when sampled high in IDLE
- busy  out  1  high from leaving IDLE until DONE
- done  out  1  one-cycle pulse at frame completion
- err  out  1  sticky response/protocol error; cleared on frame start
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  BURST_LEN-1
- m_axi_arsize  out  3  log2(STRB_WIDTH)
- m_axi_arburst  out  2  INCR (2'b01)
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rid  in  ID_WIDTH  ignored
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axis_tdata  out  DATA_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  last pixel of a line
- m_axis_tuser  out  1  first pixel of a frame

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except the constant arlen, arsize and arburst.
  - Burst, beat, pixel and line counters clear.
  - The output register empties.
  - Reset mid-frame abandons the frame immediately. arvalid and tvalid drop, and no done is issued. The RAM is reset alongside.
- IDLE:
  - When start=1 at an edge: clear err, set busy, load araddr=BASE_ADDR, go to ADDR.
  - arvalid=1 in the next cycle.
- ADDR:
  - arvalid is held high with araddr stable until the arready handshake completes.
  - On the handshake: arvalid drops the next cycle and the state goes to DATA.
- DATA:
  - rready = !m_axis_tvalid || m_axis_tready, a single-entry output register.
  - An accepted beat loads tdata the next cycle with tvalid=1. A beat is accepted at an edge when rvalid && rready.
  - tlast=1 when pixel_x == IMG_WIDTH-1.
  - tuser=1 when pixel_x==0 && line==0.
  - The beat counter counts 0..BURST_LEN-1.
  - On the final beat, check rlast: if rlast is not 1 there, or rlast=1 earlier, set err. The beat counter governs completion in both cases.
  - rresp != 0 on any beat sets err. The data is still forwarded.
- Burst completion:
  - If more bursts remain: araddr += BURST_LEN*STRB_WIDTH, go to ADDR.
  - After burst IMG_WIDTH*IMG_HEIGHT/BURST_LEN - 1: go to DRAIN.
- DRAIN: wait until the output register empties (tvalid=0, or tvalid && tready on the final pixel), then go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
  - If start is still high, the next frame's arvalid rises 2 cycles after done.
- Throughput: a full-rate beat stream passes with no bubbles while tready=1. There is 1 cycle of latency from R accept to tvalid.
- start while busy is ignored.
- The address increments with natural wrap at ADDR_WIDTH. Parameter constraints prevent any 4 KB crossing.

Test Plan:
- IMG_WIDTH=32, IMG_HEIGHT=4, BURST_LEN=16, BASE_ADDR=0, RAM preloaded with word i = i, tready=1:
  - 8 AR handshakes at 0x0000, 0x0040 … 0x01C0, each with arlen=15.
  - 128 beats with tdata 0..127.
  - tlast on beats 31, 63, 95, 127; tuser only on beat 0.
  - done pulses once and err=0.
- Same frame with tready pattern 50 cycles low, then 1,1,0,0,1…:
  - No beat is lost or duplicated.
  - tdata is held stable while tvalid && !tready.
  - rready=0 whenever the output register is full and stalled.
- arready delayed 5 cycles per burst: araddr and arvalid stay stable until the handshake, and the sequence is identical.
- Slave returns rresp=2'b10 on beat 20: err=1 stays high through done and clears on the next start. Data 0..127 is unchanged.
- Reset asserted at beat 40: next cycle arvalid=0, tvalid=0, busy=0, no done. After release with start=1, the frame restarts at 0x0000 with tuser on the first beat.
- start held high: done, then the next arvalid follows 2 cycles later and the second frame repeats the same addresses.

Source files
------------

// File: rtl/axi_frame_read_ctrl.sv
// Streams one IMG_WIDTH x IMG_HEIGHT frame from AXI4 memory as raster-order AXI-Stream, one burst in flight.
// One cycle R-accept to tvalid; a single-entry output register stalls rready under backpressure.
module axi_frame_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int BURST_LEN  = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int NUM_BURSTS = IMG_WIDTH * IMG_HEIGHT / BURST_LEN;
  localparam int BEAT_W     = $clog2(BURST_LEN + 1);
  localparam int BURST_W    = $clog2(NUM_BURSTS + 1);
  localparam int PX_W       = $clog2(IMG_WIDTH + 1);
  localparam int LINE_W     = $clog2(IMG_HEIGHT + 1);

  localparam logic [BEAT_W-1:0]     BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0]    BURST_LAST  = BURST_W'(NUM_BURSTS - 1);
  localparam logic [PX_W-1:0]       PX_LAST     = PX_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0]     LINE_LAST   = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [BURST_W-1:0]      burst_q, burst_d;
  logic [PX_W-1:0]         px_q, px_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;

  logic rready;
  logic beat_acc;
  logic last_beat;
  logic unused_rid;

  assign rready     = (state_q == S_DATA) && (!tvalid_q || m_axis_tready);
  assign beat_acc   = m_axi_rvalid && rready;
  assign last_beat  = (beat_q == BEAT_LAST);
  assign unused_rid = ^m_axi_rid;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_rready  = rready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    px_d     = px_q;
    line_d   = line_q;
    err_d    = err_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          araddr_d = BASE;
          beat_d   = '0;
          burst_d  = '0;
          px_d     = '0;
          line_d   = '0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat_acc) begin
          tdata_d  = m_axi_rdata;
          tvalid_d = 1'b1;
          tlast_d  = (px_q == PX_LAST);
          tuser_d  = (px_q == '0) && (line_q == '0);
          if (px_q == PX_LAST) begin
            px_d   = '0;
            line_d = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
          end else begin
            px_d = px_q + PX_W'(1);
          end
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // A misplaced rlast is only flagged; the beat count alone ends the burst.
          if (m_axi_rlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            beat_d = '0;
            if (burst_q == BURST_LAST) begin
              state_d = S_DRAIN;
            end else begin
              burst_d  = burst_q + BURST_W'(1);
              araddr_d = araddr_q + BURST_BYTES;
              state_d  = S_ADDR;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!tvalid_q || m_axis_tready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
      beat_q   <= '0;
      burst_q  <= '0;
      px_q     <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      px_q     <= px_d;
      line_q   <= line_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

endmodule

// File: tb/tb_axi_frame_read_ctrl.sv
// Bench for axi_frame_read_ctrl: behavioural AXI slave (word i = i), stream monitor, directed frame scenarios.
module tb_axi_frame_read_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int IW   = 8;
  localparam int W    = 32;
  localparam int H    = 4;
  localparam int BL   = 16;
  localparam int NB   = W * H / BL;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast, tuser;

  axi_frame_read_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .BURST_LEN(BL), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int ar_addr_q[$];
  int ar_len_q[$];
  int px_data_q[$];
  bit px_last_q[$];
  bit px_user_q[$];
  int done_cnt = 0;

  // slave / sink configuration
  int tr_mode  = 0;
  int ar_dly   = 0;
  int err_beat = -1;
  int cyc      = 0;
  int ar_wait  = 0;
  int r_word   = 0;
  int r_beat   = 0;
  int gbeat    = 0;
  bit r_act    = 1'b0;

  // AXI slave and tready driver: sample at negedge, drive 1 time unit after posedge
  initial begin
    bit f_ar, f_r, seen_ar, rst_s;
    int a_s;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0; tready = 1'b1;
    forever begin
      @(negedge clk);
      rst_s   = rst;
      f_ar    = arvalid && arready;
      f_r     = rvalid && rready;
      seen_ar = arvalid;
      a_s     = int'(araddr);
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_s) begin
        r_act = 1'b0; ar_wait = 0; gbeat = 0; r_beat = 0;
      end else begin
        if (f_ar) begin
          r_act = 1'b1; r_word = a_s >> 2; r_beat = 0; ar_wait = 0;
        end else if (seen_ar) begin
          ar_wait++;
        end
        if (f_r) begin
          gbeat++;
          r_beat++;
          if (r_beat == BL) r_act = 1'b0;
        end
      end
      arready = (ar_wait >= ar_dly);
      rvalid  = r_act;
      rdata   = r_word + r_beat;
      rlast   = r_act && (r_beat == BL - 1);
      rresp   = (r_act && gbeat == err_beat) ? 2'b10 : 2'b00;
      tready  = (tr_mode == 0) ? 1'b1 : ((cyc < 50) ? 1'b0 : (((cyc - 50) % 4) < 2));
    end
  end

  // monitor: logs handshakes and checks stall stability
  initial begin
    bit prev_stall = 1'b0, prev_arw = 1'b0, prev_rst = 1'b0;
    logic [DW-1:0] prev_tdata = '0;
    logic [AW-1:0] prev_araddr = '0;
    forever begin
      @(negedge clk);
      if (rst && prev_rst) begin
        if (prev_stall) begin
          chk("hold_tvalid", tvalid, 1);
          chk("hold_tdata", tdata, prev_tdata);
        end
        if (prev_arw) begin
          chk("hold_arvalid", arvalid, 1);
          chk("hold_araddr", araddr, prev_araddr);
        end
        if (tvalid && !tready) chk("rready_stall", rready, 0);
      end
      if (rst) begin
        if (arvalid && arready) begin
          ar_addr_q.push_back(int'(araddr));
          ar_len_q.push_back(int'(arlen));
        end
        if (tvalid && tready) begin
          px_data_q.push_back(int'(tdata));
          px_last_q.push_back(tlast);
          px_user_q.push_back(tuser);
        end
        if (done) done_cnt++;
      end
      prev_stall  = tvalid && !tready;
      prev_tdata  = tdata;
      prev_arw    = arvalid && !arready;
      prev_araddr = araddr;
      prev_rst    = rst;
    end
  end

  task automatic clear_log();
    ar_addr_q.delete(); ar_len_q.delete();
    px_data_q.delete(); px_last_q.delete(); px_user_q.delete();
    done_cnt = 0;
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_err_clear", err, 0);
    chk("start_arvalid", arvalid, 1);
  endtask

  task automatic wait_done(output bit err_at);
    bit got = 1'b0;
    err_at = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        err_at = err;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (got) chk("done_busy_low", busy, 0);
  endtask

  task automatic check_frame(input bit exp_err, input bit err_at);
    repeat (2) @(negedge clk);
    chk("ar_count", ar_addr_q.size(), NB);
    for (int i = 0; i < ar_addr_q.size() && i < NB; i++) begin
      chk($sformatf("ar_addr[%0d]", i), ar_addr_q[i], i * BL * 4);
      chk($sformatf("ar_len[%0d]", i), ar_len_q[i], BL - 1);
    end
    chk("beat_count", px_data_q.size(), NPIX);
    for (int i = 0; i < px_data_q.size() && i < NPIX; i++) begin
      chk($sformatf("tdata[%0d]", i), px_data_q[i], i);
      chk($sformatf("tlast[%0d]", i), px_last_q[i], (i % W) == W - 1);
      chk($sformatf("tuser[%0d]", i), px_user_q[i], i == 0);
    end
    chk("done_count", done_cnt, 1);
    chk("err_at_done", err_at, exp_err);
    chk("err_after_done", err, exp_err);
  endtask

  typedef struct {
    int tr_mode;
    int ar_dly;
    int err_beat;
    bit exp_err;
  } vec_t;

  initial begin
    vec_t vecs[5];
    bit   e, got;
    vecs[0] = '{0, 0, -1, 1'b0};   // full rate
    vecs[1] = '{1, 0, -1, 1'b0};   // 50 low then 1,1,0,0
    vecs[2] = '{0, 5, -1, 1'b0};   // slow arready
    vecs[3] = '{0, 0, 20, 1'b1};   // SLVERR on beat 20
    vecs[4] = '{1, 5, -1, 1'b0};   // combined stalls, err must clear on start

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arid", arid, 0);
    chk("rst_arlen", arlen, BL - 1);
    chk("rst_arsize", arsize, 2);
    chk("rst_arburst", arburst, 1);
    @(posedge clk); #1 rst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      tr_mode = vecs[v].tr_mode; ar_dly = vecs[v].ar_dly; err_beat = vecs[v].err_beat;
      gbeat = 0; cyc = 0;
      clear_log();
      kick();
      wait_done(e);
      check_frame(vecs[v].exp_err, e);
    end

    // reset in the middle of a frame
    @(negedge clk);
    tr_mode = 0; ar_dly = 0; err_beat = -1; gbeat = 0;
    clear_log();
    kick();
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (px_data_q.size() >= 40) begin
        got = 1'b1;
        break;
      end
    end
    chk("reach_beat40", got, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    @(posedge clk); #1 rst = 1'b1;
    clear_log();
    kick();
    wait_done(e);
    check_frame(1'b0, e);

    // start held high across frame boundary
    @(negedge clk);
    clear_log();
    @(posedge clk); #1 start = 1'b1;
    wait_done(e);
    ar_addr_q.delete(); ar_len_q.delete();
    px_data_q.delete(); px_last_q.delete(); px_user_q.delete();
    @(negedge clk);
    chk("held_gap1_arvalid", arvalid, 0);
    done_cnt = 0;
    @(negedge clk);
    chk("held_gap2_arvalid", arvalid, 1);
    @(posedge clk); #1 start = 1'b0;
    wait_done(e);
    check_frame(1'b0, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
